// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// UART receiver. It samples the serial line using the shared 16x baud tick.
// Frame format: 1 start bit, DBIT data bits sent LSB first, no parity, and a
// stop period that lasts SB_TICK ticks.
//
// Ports
//   clk          : system clock; all logic runs on the rising edge
//   reset        : asynchronous, active-high reset
//   rx           : serial line; asynchronous to clk; idles high
//   s_tick       : one-cycle pulse at 16x the baud rate
//   dout[7:0]    : last received word, zero-extended above DBIT
//   rx_done_tick : one-cycle pulse when a frame completes
//   frame_err    : the stop-bit sample of the last frame was 0
//   rx_busy      : high whenever the FSM is not in IDLE
//
// Handshake: rx_done_tick is a valid-only strobe. There is no ready signal.
// dout and frame_err are valid in the cycle where rx_done_tick is high.
// They hold their values until the next completion.
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       s_tick,
    output logic [7:0] dout,
    output logic       rx_done_tick,
    output logic       frame_err,
    output logic       rx_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [4:0] S_MID_START = 5'd7;
    localparam logic [4:0] S_MID_DATA  = 5'd15;
    localparam logic [4:0] S_STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST      = 3'(DBIT - 1);
    localparam int         ALIGN_SHIFT = 8 - DBIT;

    state_t     state_q, state_d;
    logic [4:0] s_q, s_d;
    logic [2:0] n_q, n_d;
    logic [7:0] b_q, b_d;
    logic [7:0] dout_q, dout_d;
    logic       done_q, done_d;
    logic       ferr_q, ferr_d;
    logic       busy_q, busy_d;
    logic       rx_meta_q, rx_meta_d;
    logic       rx_s_q, rx_s_d;

    always_comb begin
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
        state_d   = state_q;
        s_d       = s_q;
        n_d       = n_q;
        b_d       = b_q;
        dout_d    = dout_q;
        ferr_d    = ferr_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // The start edge is seen without waiting for s_tick.
                if (!rx_s_q) begin
                    state_d = START;
                    s_d     = 5'd0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_MID_START) begin
                        if (!rx_s_q) begin
                            state_d = DATA;
                            s_d     = 5'd0;
                            n_d     = 3'd0;
                        end else begin
                            // The line is high again at mid start bit,
                            // so treat it as a glitch.
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_MID_DATA) begin
                        b_d = {rx_s_q, b_q[7:1]};
                        s_d = 5'd0;
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        // The first bit received has moved down to
                        // b_q[ALIGN_SHIFT]. Shift it back to bit 0.
                        dout_d  = b_q >> ALIGN_SHIFT;
                        ferr_d  = ~rx_s_q;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            s_q       <= 5'd0;
            n_q       <= 3'd0;
            b_q       <= 8'd0;
            dout_q    <= 8'd0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
            state_q   <= state_d;
            s_q       <= s_d;
            n_q       <= n_d;
            b_q       <= b_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;
    assign rx_busy      = busy_q;

endmodule
